sha_msg_schedule: RTL

SHA-256 message schedule generator. It sits directly upstream of the round stage. It accepts one 512-bit padded message block and streams the 64 schedule words W0..W63, one per accepted cycle. Each word goes out with its round index, which the round stage uses to drive i_msg_blck and to address the round-constant ROM. A valid/ready handshake lets the round stage stall the stream.

---
 rtl/sha_msg_schedule.sv | 90 +++++++++
 1 files changed

// File: rtl/sha_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block and streams W0..W63 with their
// round index to the round stage, which can stall the stream with i_ready.
module sha_msg_schedule #(
  parameter int MSG_SIZE   = 512,
  parameter int WRD_SIZE   = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic [MSG_SIZE-1:0] i_msg,
  input  logic                i_ready,
  output logic                o_w_valid,
  output logic [WRD_SIZE-1:0] o_w,
  output logic [5:0]          o_round_idx,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_dbg_state
);

  localparam int         NUM_WORDS = MSG_SIZE / WRD_SIZE;
  localparam logic [5:0] LAST_IDX  = 6'(NUM_ROUNDS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t              r_state;
  logic [WRD_SIZE-1:0] r_win [NUM_WORDS];
  logic [5:0]          r_t;
  logic                r_done;

  logic                w_consume;
  logic [WRD_SIZE-1:0] w_next_word;

  function automatic logic [WRD_SIZE-1:0] f_sig0(input logic [WRD_SIZE-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WRD_SIZE-1:0] f_sig1(input logic [WRD_SIZE-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Handshake: o_w/o_round_idx are presented while o_w_valid is high and are held
  // unchanged until a rising edge with o_w_valid & i_ready consumes the word.
  assign w_consume   = (r_state == S_RUN) && i_ready;
  assign w_next_word = f_sig1(r_win[14]) + r_win[9] + f_sig0(r_win[1]) + r_win[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_done  <= 1'b0;
      for (int k = 0; k < NUM_WORDS; k++) r_win[k] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            for (int k = 0; k < NUM_WORDS; k++)
              r_win[k] <= i_msg[MSG_SIZE-1-WRD_SIZE*k -: WRD_SIZE];
            r_t     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_consume) begin
            if (r_t == LAST_IDX) begin
              // W63 stays in r_win[0]; o_w keeps it while invalid.
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_t     <= '0;
            end else begin
              for (int k = 0; k < NUM_WORDS - 1; k++) r_win[k] <= r_win[k+1];
              r_win[NUM_WORDS-1] <= w_next_word;
              r_t                <= r_t + 6'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_w_valid   = (r_state == S_RUN);
  assign o_busy      = (r_state == S_RUN);
  assign o_w         = r_win[0];
  assign o_round_idx = r_t;
  assign o_done      = r_done;
  assign o_dbg_state = r_state;

endmodule
